// File: rtl/spi_host_master.sv
// spi_host_master
//   Host-side SPI master (mode 0). Each accepted command is serialised as one
//   32-bit frame, MSB first: {cmd_write, 15-bit zero-extended address, data}.
//   Data is cmd_wdata for writes and zero for reads. MISO is sampled during
//   the 16 data bits and returned on rsp_rdata with a one-cycle rsp_valid.
//
// Ports
//   clk, reset_n              system clock, synchronous active-low reset
//   cmd_valid / cmd_ready     command handshake (see below)
//   cmd_write, cmd_addr,
//   cmd_wdata                 frame fields, latched on acceptance
//   rsp_valid, rsp_rdata      completion pulse and captured MISO data
//   busy                      a frame is in flight (SHIFT, TAIL or GAP)
//   sclk, mosi, miso, cs      SPI pins; cs active low, sclk idles low
//   dbg_state                 current FSM state, for checkers
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE. The source must
// hold cmd_valid and the fields stable until that edge. rsp_valid has no
// ready; the consumer must take it in the cycle it is high.
module spi_host_master #(
   parameter int CLK_DIV   = 4,
   parameter int ADDR_SIZE = 12
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 cmd_write,
   input  logic [ADDR_SIZE-1:0] cmd_addr,
   input  logic [15:0]          cmd_wdata,
   output logic                 rsp_valid,
   output logic [15:0]          rsp_rdata,
   output logic                 busy,
   output logic                 sclk,
   output logic                 mosi,
   input  logic                 miso,
   output logic                 cs,
   output logic [1:0]           dbg_state
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_TAIL  = 2'd2;
   localparam logic [1:0] ST_GAP   = 2'd3;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   logic [1:0]  state;
   logic [7:0]  div_cnt;
   logic [4:0]  bit_cnt;      // bits fully shifted out so far
   logic [31:0] tx_sr;
   logic [15:0] rx_sr;
   logic        sclk_q;
   logic        ready_en;     // keeps cmd_ready low while reset is held
   logic        rsp_valid_q;
   logic [15:0] rsp_rdata_q;
   logic        div_done;
   logic [31:0] frame;

   assign div_done = (div_cnt == DIV_LAST);
   assign frame    = {cmd_write, 15'(cmd_addr), (cmd_write ? cmd_wdata : 16'h0000)};

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         div_cnt     <= 8'd0;
         bit_cnt     <= 5'd0;
         tx_sr       <= 32'd0;
         rx_sr       <= 16'd0;
         sclk_q      <= 1'b0;
         ready_en    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 16'd0;
      end else begin
         ready_en    <= 1'b1;
         rsp_valid_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  tx_sr   <= frame;
                  div_cnt <= 8'd0;
                  bit_cnt <= 5'd0;
                  sclk_q  <= 1'b0;
                  state   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (div_done) begin
                  div_cnt <= 8'd0;
                  sclk_q  <= ~sclk_q;
                  if (!sclk_q) begin
                     // Rising sclk edge: sample alongside the slave. Only the
                     // data phase (bit_cnt 16..31) is kept.
                     if (bit_cnt[4]) rx_sr <= {rx_sr[14:0], miso};
                  end else begin
                     // Falling sclk edge: advance to the next bit.
                     tx_sr   <= {tx_sr[30:0], 1'b0};
                     bit_cnt <= bit_cnt + 5'd1;
                     if (bit_cnt == 5'd31) state <= ST_TAIL;
                  end
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end
            ST_TAIL: begin
               if (div_done) begin
                  div_cnt     <= 8'd0;
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= rx_sr;
                  state       <= ST_GAP;
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end
            ST_GAP: begin
               if (div_done) begin
                  div_cnt <= 8'd0;
                  state   <= ST_IDLE;
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign cmd_ready = (state == ST_IDLE) && ready_en;
   assign busy      = (state != ST_IDLE);
   assign cs        = !((state == ST_SHIFT) || (state == ST_TAIL));
   assign sclk      = sclk_q;
   assign mosi      = (state == ST_SHIFT) && tx_sr[31];
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign dbg_state = state;

endmodule

// File: tb/tb_spi_host_master.sv
// Bench for spi_host_master. Instance A uses CLK_DIV=4, instance B CLK_DIV=1.
// A negedge monitor on the selected instance acts as SPI slave: it rebuilds
// the MOSI frame from sclk rises, drives MISO after each sclk fall, and
// scores frames and responses against expectation queues.
module tb_spi_host_master;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cmd_valid_a = 1'b0;
   logic        cmd_valid_b = 1'b0;
   logic        cmd_write = 1'b0;
   logic [11:0] cmd_addr = 12'd0;
   logic [15:0] cmd_wdata = 16'd0;
   logic        miso = 1'b0;

   logic        cmd_ready_a, rsp_valid_a, busy_a, sclk_a, mosi_a, cs_a;
   logic [15:0] rsp_rdata_a;
   logic [1:0]  dbg_a;
   logic        cmd_ready_b, rsp_valid_b, busy_b, sclk_b, mosi_b, cs_b;
   logic [15:0] rsp_rdata_b;
   logic [1:0]  dbg_b;

   spi_host_master #(.CLK_DIV(4), .ADDR_SIZE(12)) dut_a (
      .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .busy(busy_a),
      .sclk(sclk_a), .mosi(mosi_a), .miso(miso), .cs(cs_a), .dbg_state(dbg_a));

   spi_host_master #(.CLK_DIV(1), .ADDR_SIZE(12)) dut_b (
      .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .busy(busy_b),
      .sclk(sclk_b), .mosi(mosi_b), .miso(miso), .cs(cs_b), .dbg_state(dbg_b));

   // ---------------- clock / reset / bookkeeping ----------------
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;                 // at a negedge, the current cycle is cyc+1
   always @(posedge clk) cyc <= cyc + 1;

   bit sel = 1'b0;              // 0 = instance A, 1 = instance B
   int div_sel;
   logic mcs, msclk, mmosi, mrsp_valid, mready, mbusy;
   logic [15:0] mrdata;
   assign mcs        = sel ? cs_b        : cs_a;
   assign msclk      = sel ? sclk_b      : sclk_a;
   assign mmosi      = sel ? mosi_b      : mosi_a;
   assign mrsp_valid = sel ? rsp_valid_b : rsp_valid_a;
   assign mready     = sel ? cmd_ready_b : cmd_ready_a;
   assign mbusy      = sel ? busy_b      : busy_a;
   assign mrdata     = sel ? rsp_rdata_b : rsp_rdata_a;
   assign div_sel    = sel ? 1 : 4;

   // ---------------- scoreboard ----------------
   logic [31:0] exp_frame_q[$];
   logic [16:0] exp_rsp_q[$];   // {check_data, data}
   logic [15:0] miso_word = 16'd0;

   logic        prev_cs = 1'b1;
   logic        prev_sclk = 1'b0;
   logic [31:0] rx_frame = 32'd0;
   int          rises = 0;
   int          falls = 0;
   int          rsp_cnt = 0;

   always @(negedge clk) begin
      logic [31:0] ef;
      logic [16:0] er;
      if (prev_cs && !mcs) begin
         rx_frame = 32'd0; rises = 0; falls = 0;
         miso = 1'($urandom);
      end
      if (!mcs && !prev_sclk && msclk) begin
         rx_frame = {rx_frame[30:0], mmosi};
         rises++;
      end
      if (!mcs && prev_sclk && !msclk) begin
         falls++;
         // Header-phase MISO is noise; the data word starts after fall 16.
         if (falls >= 16 && falls < 32) miso = miso_word[31 - falls];
         else miso = 1'($urandom);
      end
      if (!prev_cs && mcs && reset_n) begin
         n_chk++;
         if (exp_frame_q.size() == 0) begin
            n_fail++;
            $display("FAIL frame_unexpected: got %h, none expected", rx_frame);
         end else begin
            ef = exp_frame_q.pop_front();
            if (rx_frame !== ef) begin
               n_fail++;
               $display("FAIL frame_bits: got %h, expected %h", rx_frame, ef);
            end
         end
         n_chk++;
         if (rises !== 32) begin
            n_fail++;
            $display("FAIL sclk_rises: got %0d, expected 32", rises);
         end
      end
      if (mrsp_valid) begin
         rsp_cnt++;
         n_chk++;
         if (exp_rsp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rsp_unexpected: rdata %h", mrdata);
         end else begin
            er = exp_rsp_q.pop_front();
            if (er[16] && (mrdata !== er[15:0])) begin
               n_fail++;
               $display("FAIL rsp_rdata: got %h, expected %h", mrdata, er[15:0]);
            end
         end
      end
      prev_cs   = mcs;
      prev_sclk = msclk;
   end

   // ---------------- driver tasks ----------------
   // Called at a negedge. Returns at the negedge of the acceptance cycle T0.
   task automatic start_cmd(input bit push_exp, input bit wr, input logic [11:0] addr,
                            input logic [15:0] wd, input logic [15:0] rd, output int t0);
      cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
      miso_word = wr ? 16'($urandom) : rd;
      if (push_exp) begin
         exp_frame_q.push_back({wr, 3'b000, addr, (wr ? wd : 16'h0000)});
         exp_rsp_q.push_back({!wr, rd});
      end
      if (sel) cmd_valid_b = 1'b1; else cmd_valid_a = 1'b1;
      t0 = -1;
      for (int i = 0; i < 2000; i++) begin
         if (mready) begin t0 = cyc + 1; break; end
         @(negedge clk);
      end
      n_chk++;
      if (t0 < 0) begin
         n_fail++;
         $display("FAIL accept_timeout: cmd_ready never seen, expected within 2000 cycles");
      end
   endtask

   // Follows one frame from T0+1, dropping cmd_valid on the first cycle.
   task automatic track_frame(output int t_cs, output int t_rsp, output int t_rdy);
      t_cs = -1; t_rsp = -1; t_rdy = -1;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (i == 0) begin cmd_valid_a = 1'b0; cmd_valid_b = 1'b0; end
         if (t_cs < 0 && !mcs) t_cs = cyc + 1;
         if (t_rsp < 0 && mrsp_valid) t_rsp = cyc + 1;
         if (t_rsp >= 0 && mready) begin t_rdy = cyc + 1; break; end
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      n_chk++;
      if ({cs_a, sclk_a, mosi_a, cmd_ready_a, busy_a, rsp_valid_a, dbg_a} !== 8'b1000_0000) begin
         n_fail++;
         $display("FAIL reset_outputs: cs,sclk,mosi,ready,busy,rsp,state = %b, expected 10000000",
                  {cs_a, sclk_a, mosi_a, cmd_ready_a, busy_a, rsp_valid_a, dbg_a});
      end
      n_chk++;
      if (rsp_rdata_a !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_rdata: got %h, expected 0000", rsp_rdata_a);
      end
      reset_n = 1'b1;
      @(negedge clk);
      n_chk++;
      if (cmd_ready_a !== 1'b1 || cmd_ready_b !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_after_reset: got %b%b, expected 11", cmd_ready_a, cmd_ready_b);
      end
   endtask

   task automatic check_timing(input string name, input int t0, input int t_cs,
                               input int t_rsp, input int t_rdy);
      n_chk++;
      if (t_cs !== t0 + 1) begin
         n_fail++;
         $display("FAIL %s_cs_fall: cycle %0d, expected %0d", name, t_cs - t0, 1);
      end
      n_chk++;
      if (t_rsp !== t0 + 1 + 65 * div_sel) begin
         n_fail++;
         $display("FAIL %s_rsp_valid: cycle %0d, expected %0d", name, t_rsp - t0, 1 + 65 * div_sel);
      end
      n_chk++;
      if (t_rdy !== t0 + 1 + 66 * div_sel) begin
         n_fail++;
         $display("FAIL %s_ready: cycle %0d, expected %0d", name, t_rdy - t0, 1 + 66 * div_sel);
      end
   endtask

   task automatic test_write();
      int t0, t_cs, t_rsp, t_rdy;
      start_cmd(1'b1, 1'b1, 12'h0A5, 16'hBEEF, 16'h0000, t0);
      @(negedge clk);
      n_chk++;
      if ({cs_a, busy_a, cmd_ready_a, sclk_a, mosi_a} !== 5'b01001) begin
         n_fail++;
         $display("FAIL write_first_cycle: cs,busy,ready,sclk,mosi = %b, expected 01001",
                  {cs_a, busy_a, cmd_ready_a, sclk_a, mosi_a});
      end
      cmd_valid_a = 1'b0;
      track_frame(t_cs, t_rsp, t_rdy);
      // track_frame began one cycle late, so the cs fall was at T0+1.
      check_timing("write", t0, t0 + 1, t_rsp, t_rdy);
   endtask

   task automatic test_read();
      int t0, t_cs, t_rsp, t_rdy;
      start_cmd(1'b1, 1'b0, 12'h3FF, 16'hFFFF, 16'h1234, t0);
      track_frame(t_cs, t_rsp, t_rdy);
      check_timing("read", t0, t_cs, t_rsp, t_rdy);
      start_cmd(1'b1, 1'b0, 12'h5A0, 16'h0000, 16'(  $urandom_range(0, 65535)), t0);
      exp_rsp_q[exp_rsp_q.size()-1][15:0] = miso_word;
      track_frame(t_cs, t_rsp, t_rdy);
   endtask

   task automatic test_back_to_back();
      int t0, t_r, t_rise, t_cs, t_rsp, t_rdy;
      start_cmd(1'b1, 1'b1, 12'h123, 16'h5AA5, 16'h0000, t0);
      @(negedge clk);
      // cmd_valid stays high; next command's fields are staged mid-frame.
      cmd_write = 1'b0; cmd_addr = 12'hC3C; cmd_wdata = 16'hFFFF;
      miso_word = 16'hA5C3;
      exp_frame_q.push_back({1'b0, 3'b000, 12'hC3C, 16'h0000});
      exp_rsp_q.push_back({1'b1, 16'hA5C3});
      t_r = -1; t_rise = -1;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (t_rise < 0 && mcs) t_rise = cyc + 1;
         if (mready) begin t_r = cyc + 1; break; end
      end
      track_frame(t_cs, t_rsp, t_rdy);
      n_chk++;
      if (t_cs !== t_r + 1) begin
         n_fail++;
         $display("FAIL b2b_cs_fall: %0d cycles after ready, expected 1", t_cs - t_r);
      end
      // cs is high through GAP (CLK_DIV cycles) plus the IDLE acceptance cycle.
      n_chk++;
      if (t_cs - t_rise !== 5) begin
         n_fail++;
         $display("FAIL b2b_cs_high: %0d cycles, expected 5", t_cs - t_rise);
      end
      n_chk++;
      if (t_r - t0 !== 66 * 4 + 1) begin
         n_fail++;
         $display("FAIL b2b_period: %0d cycles, expected %0d", t_r - t0, 66 * 4 + 1);
      end
      check_timing("b2b", t_r, t_cs, t_rsp, t_rdy);
   endtask

   task automatic test_reset_mid_frame();
      int t0, t_cs, t_rsp, t_rdy, rc;
      bit reached;
      start_cmd(1'b0, 1'b1, 12'hFFF, 16'hAAAA, 16'h0000, t0);
      reached = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (i == 0) cmd_valid_a = 1'b0;
         if (rises >= 11) begin reached = 1'b1; break; end
      end
      n_chk++;
      if (!reached) begin
         n_fail++;
         $display("FAIL abort_progress: %0d rises, expected at least 11", rises);
      end
      rc = rsp_cnt;
      reset_n = 1'b0;
      @(negedge clk);
      n_chk++;
      if ({cs_a, sclk_a, busy_a, mosi_a} !== 4'b1000) begin
         n_fail++;
         $display("FAIL abort_outputs: cs,sclk,busy,mosi = %b, expected 1000",
                  {cs_a, sclk_a, busy_a, mosi_a});
      end
      @(negedge clk);
      reset_n = 1'b1;
      repeat (300) @(negedge clk);
      n_chk++;
      if (rsp_cnt !== rc) begin
         n_fail++;
         $display("FAIL abort_rsp: %0d responses, expected 0", rsp_cnt - rc);
      end
      start_cmd(1'b1, 1'b1, 12'h010, 16'h0001, 16'h0000, t0);
      track_frame(t_cs, t_rsp, t_rdy);
      check_timing("after_abort", t0, t_cs, t_rsp, t_rdy);
   endtask

   task automatic test_clkdiv1();
      int t0, t_cs, t_rsp, t_rdy, bad;
      sel = 1'b1;
      @(negedge clk);
      start_cmd(1'b1, 1'b1, 12'h000, 16'hFFFF, 16'h0000, t0);
      bad = 0;
      t_rsp = -1;
      for (int j = 1; j <= 66; j++) begin
         @(negedge clk);
         if (j == 1) cmd_valid_b = 1'b0;
         // Cycle T0+j: sclk high on even j for the 64 shift cycles.
         if (j <= 64 && sclk_b !== ((j % 2) == 0)) bad++;
         if (t_rsp < 0 && rsp_valid_b) t_rsp = cyc + 1;
      end
      n_chk++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL div1_sclk_toggle: %0d bad cycles, expected 0", bad);
      end
      n_chk++;
      if (t_rsp !== t0 + 66) begin
         n_fail++;
         $display("FAIL div1_rsp_valid: cycle %0d, expected 66", t_rsp - t0);
      end
      @(negedge clk);
      n_chk++;
      if (cmd_ready_b !== 1'b1 || busy_b !== 1'b0) begin
         n_fail++;
         $display("FAIL div1_ready: ready,busy = %b%b, expected 10", cmd_ready_b, busy_b);
      end
      sel = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_reset_mid_frame();
      test_clkdiv1();
      repeat (4) @(negedge clk);
      n_chk++;
      if (exp_frame_q.size() != 0 || exp_rsp_q.size() != 0) begin
         n_fail++;
         $display("FAIL queues_drained: %0d frames, %0d responses left, expected 0 0",
                  exp_frame_q.size(), exp_rsp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
